mem_arbiter: RTL and testbench

Two-requester arbiter sharing one memory slave port (8-bit address, 16-bit data, valid/ready handshake with `wr_rd` direction select). It sits between two bus-functional masters and the memory model. It registers the winning request, drives it onto the memory port and waits for `ready`. It then returns read data and a one-cycle `ready` pulse to the granted requester. Arbitration is round-robin, or fixed-priority under configuration.

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one memory slave port between two requesters. A request seen in
// IDLE is registered onto the mem_* port and held (BUSY) until mem_ready.
// The captured read data (or zero for a write) is then returned to the
// granted requester with a one-cycle ready pulse (RESP). Arbitration never
// happens in RESP, so the completing requester, whose valid is still high in
// that cycle, cannot be granted again.
//
// Configuration:
//   MEM_ARB_RR_EN  defined   : round-robin tie-break; the requester that did
//                              not win last time wins a tie.
//                  undefined : fixed priority; r0 always wins a tie.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   rX_addr/wdata/wr_rd   requester X command (wr_rd: 1 = write, 0 = read)
//   rX_valid              requester X pending, held until rX_ready
//   rX_rdata              registered read data, valid while rX_ready = 1
//   rX_ready              one-cycle completion pulse
//   mem_addr/wdata/wr_rd  registered command to memory
//   mem_valid             memory request, held until mem_ready
//   mem_rdata, mem_ready  memory read data and accept/complete
//   grant                 one-hot owner: 01 = r0, 10 = r1, 00 = none
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [WIDTH-1:0]      r0_wdata,
  input  logic                  r0_wr_rd,
  input  logic                  r0_valid,
  output logic [WIDTH-1:0]      r0_rdata,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0]      r1_wdata,
  input  logic                  r1_wr_rd,
  input  logic                  r1_valid,
  output logic [WIDTH-1:0]      r1_rdata,
  output logic                  r1_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_wr_rd,
  output logic                  mem_valid,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ready,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                  mem_wr_rd_q, mem_wr_rd_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [1:0]            grant_q, grant_d;
  // 1 = r1 was granted last, 0 = r0 was granted last.
  logic                  last_grant_q, last_grant_d;
  logic [WIDTH-1:0]      r0_rdata_q, r0_rdata_d;
  logic [WIDTH-1:0]      r1_rdata_q, r1_rdata_d;
  logic                  r0_ready_q, r0_ready_d;
  logic                  r1_ready_q, r1_ready_d;

  // Winner selection. tie_r1 decides who wins when both are valid.
  logic            tie_r1;
  logic            pick_r1;
  logic [WIDTH-1:0] cap_data;

`ifdef MEM_ARB_RR_EN
  // Last winner was r0 -> r1 takes the tie, and vice versa.
  assign tie_r1 = ~last_grant_q;
`else
  assign tie_r1 = 1'b0;
  // last_grant is still tracked but does not steer selection in this build.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  assign pick_r1  = r1_valid & (~r0_valid | tie_r1);
  // Writes return zero so a stale read value is never presented as write data.
  assign cap_data = mem_wr_rd_q ? '0 : mem_rdata;

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wr_rd_d  = mem_wr_rd_q;
    mem_valid_d  = mem_valid_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    r0_rdata_d   = r0_rdata_q;
    r1_rdata_d   = r1_rdata_q;
    // Ready is a pulse: it is only ever raised for the single RESP cycle.
    r0_ready_d   = 1'b0;
    r1_ready_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (r0_valid || r1_valid) begin
          if (pick_r1) begin
            mem_addr_d  = r1_addr;
            mem_wdata_d = r1_wdata;
            mem_wr_rd_d = r1_wr_rd;
            grant_d     = 2'b10;
          end else begin
            mem_addr_d  = r0_addr;
            mem_wdata_d = r0_wdata;
            mem_wr_rd_d = r0_wr_rd;
            grant_d     = 2'b01;
          end
          last_grant_d = pick_r1;
          mem_valid_d  = 1'b1;
          state_d      = StBusy;
        end
      end

      StBusy: begin
        // mem_* stay untouched until the memory completes the access.
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (grant_q[1]) begin
            r1_rdata_d = cap_data;
            r1_ready_d = 1'b1;
          end else begin
            r0_rdata_d = cap_data;
            r0_ready_d = 1'b1;
          end
          state_d = StResp;
        end
      end

      StResp: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end

      default: begin
        mem_valid_d = 1'b0;
        grant_d     = 2'b00;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_rd_q  <= 1'b0;
      mem_valid_q  <= 1'b0;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;  // r0 wins the first tie
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
      r0_ready_q   <= 1'b0;
      r1_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_rd_q  <= mem_wr_rd_d;
      mem_valid_q  <= mem_valid_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      r0_rdata_q   <= r0_rdata_d;
      r1_rdata_q   <= r1_rdata_d;
      r0_ready_q   <= r0_ready_d;
      r1_ready_q   <= r1_ready_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr_rd = mem_wr_rd_q;
  assign mem_valid = mem_valid_q;
  assign grant     = grant_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign r0_ready  = r0_ready_q;
  assign r1_ready  = r1_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are sampled
// 1 ns after each rising edge. A small array stands in for the memory
// contents so reads return what was written or preloaded.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_wr_rd, r1_wr_rd;
  logic        r0_valid, r1_valid;
  logic [15:0] r0_rdata, r1_rdata;
  logic        r0_ready, r1_ready;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wr_rd;
  logic        mem_valid;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [1:0]  grant;

  logic [15:0] model [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH (8),
    .WIDTH      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_wr_rd  (r0_wr_rd),
    .r0_valid  (r0_valid),
    .r0_rdata  (r0_rdata),
    .r0_ready  (r0_ready),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_wr_rd  (r1_wr_rd),
    .r1_valid  (r1_valid),
    .r1_rdata  (r1_rdata),
    .r1_ready  (r1_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr_rd (mem_wr_rd),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .grant     (grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from a single requester, starting in IDLE.
  // lat = number of cycles mem_valid is seen high before mem_ready is sampled.
  task automatic do_txn(input bit port, input logic [7:0] addr, input logic [15:0] wd,
                        input logic wr, input int lat, input logic [15:0] exp_rd);
    if (port) begin
      r1_addr = addr; r1_wdata = wd; r1_wr_rd = wr; r1_valid = 1'b1;
    end else begin
      r0_addr = addr; r0_wdata = wd; r0_wr_rd = wr; r0_valid = 1'b1;
    end
    step();
    check("txn_grant", {30'd0, grant}, port ? 32'h2 : 32'h1);
    check("txn_mem_valid", {31'd0, mem_valid}, 32'h1);
    check("txn_mem_addr", {24'd0, mem_addr}, {24'd0, addr});
    check("txn_mem_wr_rd", {31'd0, mem_wr_rd}, {31'd0, wr});
    if (wr) check("txn_mem_wdata", {16'd0, mem_wdata}, {16'd0, wd});
    for (int i = 1; i < lat; i++) begin
      step();
      check("txn_valid_hold", {31'd0, mem_valid}, 32'h1);
      check("txn_addr_hold", {24'd0, mem_addr}, {24'd0, addr});
      check("txn_no_early_ready", {30'd0, r1_ready, r0_ready}, 32'h0);
    end
    mem_ready = 1'b1;
    if (mem_wr_rd) begin
      model[mem_addr] = mem_wdata;
      mem_rdata = 16'hDEAD;  // must be ignored on a write
    end else begin
      mem_rdata = model[mem_addr];
    end
    step();
    mem_ready = 1'b0;
    mem_rdata = 16'h0;
    check("txn_ready", {30'd0, r1_ready, r0_ready}, port ? 32'h2 : 32'h1);
    check("txn_rdata", {16'd0, port ? r1_rdata : r0_rdata}, {16'd0, exp_rd});
    check("txn_valid_drop", {31'd0, mem_valid}, 32'h0);
    if (port) r1_valid = 1'b0; else r0_valid = 1'b0;
    step();
    check("txn_ready_off", {30'd0, r1_ready, r0_ready}, 32'h0);
    check("txn_grant_off", {30'd0, grant}, 32'h0);
  endtask

  initial begin
    logic [1:0] exp_g;
    for (int i = 0; i < 256; i++) model[i] = 16'h0;
    model[8'h20] = 16'h2020;
    model[8'h30] = 16'h3030;
    model[8'h40] = 16'h5A5A;

    rst = 1'b1;
    r0_addr = 8'h0; r0_wdata = 16'h0; r0_wr_rd = 1'b0; r0_valid = 1'b0;
    r1_addr = 8'h0; r1_wdata = 16'h0; r1_wr_rd = 1'b0; r1_valid = 1'b0;
    mem_rdata = 16'h0; mem_ready = 1'b0;
    step(); step(); step();
    check("rst_mem_valid", {31'd0, mem_valid}, 32'h0);
    check("rst_grant", {30'd0, grant}, 32'h0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'h0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'h0);
    check("rst_ready", {30'd0, r1_ready, r0_ready}, 32'h0);
    check("rst_rdata", {r1_rdata, r0_rdata}, 32'h0);
    rst = 1'b0;
    step();
    check("idle_no_req", {31'd0, mem_valid}, 32'h0);

    // r0 write 0x10 <- BEEF, memory ready one cycle after valid.
    do_txn(1'b0, 8'h10, 16'hBEEF, 1'b1, 1, 16'h0000);
    // r1 read 0x10, memory ready delayed 5 cycles.
    do_txn(1'b1, 8'h10, 16'h0000, 1'b0, 5, 16'hBEEF);
    step();
    check("rdata_holds", {16'd0, r1_rdata}, 32'hBEEF);

    // Contention: both requesters held valid across four transactions.
    r0_addr = 8'h20; r0_wr_rd = 1'b0; r0_valid = 1'b1;
    r1_addr = 8'h30; r1_wr_rd = 1'b0; r1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      step();
      check("cont_grant", {30'd0, grant}, {30'd0, exp_g});
      check("cont_addr", {24'd0, mem_addr}, exp_g[1] ? 32'h30 : 32'h20);
      mem_ready = 1'b1;
      mem_rdata = model[mem_addr];
      step();
      mem_ready = 1'b0;
      check("cont_ready", {30'd0, r1_ready, r0_ready}, {30'd0, exp_g});
      check("cont_rdata", {16'd0, exp_g[1] ? r1_rdata : r0_rdata},
            exp_g[1] ? 32'h3030 : 32'h2020);
      step();
      check("cont_gap", {29'd0, mem_valid, grant}, 32'h0);
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    step();

    // Reset while a read is outstanding in BUSY.
    r1_addr = 8'h40; r1_wr_rd = 1'b0; r1_valid = 1'b1;
    step();
    check("abort_busy", {29'd0, mem_valid, grant}, 32'h6);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", {31'd0, mem_valid}, 32'h0);
    check("abort_grant", {30'd0, grant}, 32'h0);
    check("abort_ready", {30'd0, r1_ready, r0_ready}, 32'h0);
    check("abort_rdata", {16'd0, r1_rdata}, 32'h0);
    step();
    check("reissue_valid", {31'd0, mem_valid}, 32'h1);
    check("reissue_addr", {24'd0, mem_addr}, 32'h40);
    check("reissue_grant", {30'd0, grant}, 32'h2);
    mem_ready = 1'b1;
    mem_rdata = model[mem_addr];
    step();
    mem_ready = 1'b0;
    check("reissue_ready", {30'd0, r1_ready, r0_ready}, 32'h2);
    check("reissue_rdata", {16'd0, r1_rdata}, 32'h5A5A);
    r1_valid = 1'b0;
    step();

    // Write then read at the top address from different ports.
    do_txn(1'b0, 8'hFF, 16'h1234, 1'b1, 2, 16'h0000);
    do_txn(1'b1, 8'hFF, 16'h0000, 1'b0, 1, 16'h1234);
    check("r0_rdata_hold", {16'd0, r0_rdata}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
